fetch_sequencer: RTL and testbench

Parametrised program-sequencing front end for the 9-bit-ISA core. It replaces the fixed program counter, the peeked-at jump table and the hard-coded `prog_ctr == 128` done test with one block. The block has:
- a req/done run handshake,
- a runtime-writable jump-target table,
- absolute, relative, call and return control flow,
- a bounded return-address stack with fault detection.

It sits between the control decoder (which drives the jump/call/return strobes) and `instr_ROM`, which it addresses through `prog_ctr`.

---
 rtl/fetch_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// ---------------------------------------------------------------------------
// Program-sequencing front end for the 9-bit-ISA core. Produces the
// instruction address for instr_ROM, runs a req/done handshake, holds a
// runtime-writable jump-target table and a bounded return-address stack.
//
// Parameters:
//   D        program counter width
//   LW       jump-table address width (2**LW entries of D bits)
//   SD       return-stack depth
//   END_ADDR PC value that ends a program
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req                   start request (IDLE and DONE only)
//   stall                 hold PC, ignore all control strobes
//   abs_en/rel_en         absolute / relative jump
//   call_en/ret_en        call through table / return from stack
//   lut_sel, rel_off      jump-table entry, signed relative offset
//   lut_wr_en/addr/data   jump-table write port
//   prog_ctr              registered instruction address
//   running/done/fault    registered state flags
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int D        = 12,
    parameter int LW       = 3,
    parameter int SD       = 4,
    parameter int END_ADDR = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall,
    input  logic          abs_en,
    input  logic          rel_en,
    input  logic          call_en,
    input  logic          ret_en,
    input  logic [LW-1:0] lut_sel,
    input  logic [D-1:0]  rel_off,
    input  logic          lut_wr_en,
    input  logic [LW-1:0] lut_wr_addr,
    input  logic [D-1:0]  lut_wr_data,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic          fault
);

    localparam int CW = $clog2(SD + 1);
    localparam int IW = (SD > 1) ? $clog2(SD) : 1;
    localparam int LN = 2 ** LW;

    localparam logic [D-1:0]  PC_ZERO   = {D{1'b0}};
    localparam logic [D-1:0]  PC_ONE    = D'(1);
    localparam logic [D-1:0]  END_PC    = D'(END_ADDR);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(SD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [D-1:0]    pc_r;
    logic [D-1:0]    pc_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;
    logic            push_s;
    logic [D-1:0]    lut_r   [LN];
    logic [D-1:0]    stack_r [SD];

    // Candidate action decoded from the strobes; consumed only in RUN.
    logic [D-1:0]    sel_pc_s;
    logic [CW-1:0]   sel_cnt_s;
    logic            sel_push_s;
    logic            sel_fault_s;
    logic [IW-1:0]   top_idx_s;
    logic [IW-1:0]   push_idx_s;
    logic [D-1:0]    push_val_s;

    assign prog_ctr = pc_r;

    // Select the winning control-flow action: ret > call > abs > rel > increment.
    always_comb begin
        sel_pc_s    = pc_r + PC_ONE;
        sel_cnt_s   = cnt_r;
        sel_push_s  = 1'b0;
        sel_fault_s = 1'b0;
        top_idx_s   = IW'(cnt_r - CNT_ONE);
        push_idx_s  = IW'(cnt_r);
        push_val_s  = pc_r + PC_ONE;
        if (ret_en) begin
            if (cnt_r == CNT_ZERO) begin
                sel_fault_s = 1'b1;
            end else begin
                sel_pc_s  = stack_r[top_idx_s];
                sel_cnt_s = cnt_r - CNT_ONE;
            end
        end else if (call_en) begin
            if (cnt_r == CNT_FULL) begin
                sel_fault_s = 1'b1;
            end else begin
                sel_pc_s   = lut_r[lut_sel];
                sel_cnt_s  = cnt_r + CNT_ONE;
                sel_push_s = 1'b1;
            end
        end else if (abs_en) begin
            sel_pc_s = lut_r[lut_sel];
        end else if (rel_en) begin
            // D-bit add wraps modulo 2**D, which is the two's-complement offset.
            sel_pc_s = pc_r + rel_off;
        end else begin
            sel_pc_s = pc_r + PC_ONE;
        end
    end

    // Next-state and next-PC logic for the sequencer FSM.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        cnt_s   = cnt_r;
        push_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                pc_s = PC_ZERO;
                if (req) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (stall) begin
                    state_s = S_RUN;
                end else if (sel_fault_s) begin
                    // Fault outranks the end check; PC and stack are frozen.
                    state_s = S_FAULT;
                end else if (sel_pc_s == END_PC) begin
                    state_s = S_DONE;
                    pc_s    = END_PC;
                    cnt_s   = sel_cnt_s;
                    push_s  = sel_push_s;
                end else begin
                    state_s = S_RUN;
                    pc_s    = sel_pc_s;
                    cnt_s   = sel_cnt_s;
                    push_s  = sel_push_s;
                end
            end
            S_DONE: begin
                pc_s = END_PC;
                if (req) begin
                    state_s = S_RUN;
                    pc_s    = PC_ZERO;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_FAULT: begin
                state_s = S_FAULT;
            end
            default: begin
                state_s = S_IDLE;
                pc_s    = PC_ZERO;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, PC, stack, jump table and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            pc_r    <= PC_ZERO;
            cnt_r   <= CNT_ZERO;
            running <= 1'b0;
            done    <= 1'b0;
            fault   <= 1'b0;
            for (int i = 0; i < LN; i++) begin
                lut_r[i] <= PC_ZERO;
            end
            for (int i = 0; i < SD; i++) begin
                stack_r[i] <= PC_ZERO;
            end
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            cnt_r   <= cnt_s;
            running <= (state_s == S_RUN);
            done    <= (state_s == S_DONE);
            fault   <= (state_s == S_FAULT);
            if (push_s) begin
                stack_r[push_idx_s] <= push_val_s;
            end
            // Table writes are independent of state and stall; reads in the
            // same cycle see the previous contents.
            if (lut_wr_en) begin
                lut_r[lut_wr_addr] <= lut_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed bench for fetch_sequencer with END_ADDR=8 so a full run is short.
// Inputs change 1 ns after the rising edge; outputs are checked at that point.
module tb_fetch_sequencer;

    localparam int D  = 12;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic          stall = 1'b0;
    logic          abs_en = 1'b0;
    logic          rel_en = 1'b0;
    logic          call_en = 1'b0;
    logic          ret_en = 1'b0;
    logic [LW-1:0] lut_sel = 3'd0;
    logic [D-1:0]  rel_off = 12'd0;
    logic          lut_wr_en = 1'b0;
    logic [LW-1:0] lut_wr_addr = 3'd0;
    logic [D-1:0]  lut_wr_data = 12'd0;
    logic [D-1:0]  prog_ctr;
    logic          running;
    logic          done;
    logic          fault;

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(.D(12), .LW(3), .SD(4), .END_ADDR(8)) dut (
        .clk(clk), .reset(reset), .req(req), .stall(stall),
        .abs_en(abs_en), .rel_en(rel_en), .call_en(call_en), .ret_en(ret_en),
        .lut_sel(lut_sel), .rel_off(rel_off),
        .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
        .prog_ctr(prog_ctr), .running(running), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    // One clock edge, then return all single-cycle strobes to idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        reset = 1'b0; req = 1'b0; stall = 1'b0;
        abs_en = 1'b0; rel_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
        lut_wr_en = 1'b0;
    endtask

    task automatic wr_lut(input logic [LW-1:0] a, input logic [D-1:0] v);
        lut_wr_en = 1'b1; lut_wr_addr = a; lut_wr_data = v;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        checks++; if (prog_ctr !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h expected 000", prog_ctr); end
        checks++; if ({running, done, fault} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {running, done, fault}); end
        cyc();
        checks++; if (prog_ctr !== 12'h000 || running !== 1'b0) begin errors++; $display("FAIL idle_hold: got pc %h run %b expected 000/0", prog_ctr, running); end
    endtask

    task automatic test_run_to_done();
        req = 1'b1;
        cyc();
        checks++; if (prog_ctr !== 12'h000 || running !== 1'b1) begin errors++; $display("FAIL start: got pc %h run %b expected 000/1", prog_ctr, running); end
        for (int i = 1; i < 8; i++) begin
            cyc();
            checks++; if (prog_ctr !== 12'(i) || done !== 1'b0) begin errors++; $display("FAIL run_inc: got pc %h done %b expected %h/0", prog_ctr, done, 12'(i)); end
        end
        cyc();
        checks++; if (prog_ctr !== 12'h008 || done !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL run_end: got pc %h done %b run %b expected 008/1/0", prog_ctr, done, running); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if (prog_ctr !== 12'h008 || done !== 1'b1) begin errors++; $display("FAIL done_hold: got pc %h done %b expected 008/1", prog_ctr, done); end
        end
        req = 1'b1;
        cyc();
        checks++; if (prog_ctr !== 12'h000 || running !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL restart: got pc %h run %b done %b expected 000/1/0", prog_ctr, running, done); end
    endtask

    task automatic test_abs_jump();
        wr_lut(3'd2, 12'h005);
        checks++; if (prog_ctr !== 12'h001) begin errors++; $display("FAIL abs_pre: got %h expected 001", prog_ctr); end
        abs_en = 1'b1; lut_sel = 3'd2;
        cyc();
        checks++; if (prog_ctr !== 12'h005) begin errors++; $display("FAIL abs_jump: got %h expected 005", prog_ctr); end
        abs_en = 1'b1; lut_sel = 3'd2;
        lut_wr_en = 1'b1; lut_wr_addr = 3'd2; lut_wr_data = 12'h009;
        cyc();
        checks++; if (prog_ctr !== 12'h005) begin errors++; $display("FAIL abs_old_value: got %h expected 005", prog_ctr); end
        abs_en = 1'b1; lut_sel = 3'd2;
        cyc();
        checks++; if (prog_ctr !== 12'h009) begin errors++; $display("FAIL abs_new_value: got %h expected 009", prog_ctr); end
    endtask

    task automatic test_rel_jump();
        wr_lut(3'd3, 12'h005);
        abs_en = 1'b1; lut_sel = 3'd3;
        cyc();
        rel_en = 1'b1; rel_off = 12'hFFD;
        cyc();
        checks++; if (prog_ctr !== 12'h002) begin errors++; $display("FAIL rel_back: got %h expected 002", prog_ctr); end
        rel_en = 1'b1; rel_off = 12'hFFE;
        cyc();
        rel_en = 1'b1; rel_off = 12'hFFF;
        cyc();
        checks++; if (prog_ctr !== 12'hFFF) begin errors++; $display("FAIL rel_wrap: got %h expected fff", prog_ctr); end
        cyc();
        checks++; if (prog_ctr !== 12'h000) begin errors++; $display("FAIL inc_wrap: got %h expected 000", prog_ctr); end
        req = 1'b1;
        cyc();
        checks++; if (prog_ctr !== 12'h001 || running !== 1'b1) begin errors++; $display("FAIL req_in_run: got pc %h run %b expected 001/1", prog_ctr, running); end
    endtask

    task automatic test_end_via_jump();
        wr_lut(3'd4, 12'h008);
        abs_en = 1'b1; lut_sel = 3'd4;
        cyc();
        checks++; if (prog_ctr !== 12'h008 || done !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL jump_end: got pc %h done %b run %b expected 008/1/0", prog_ctr, done, running); end
        req = 1'b1;
        cyc();
        checks++; if (prog_ctr !== 12'h000 || running !== 1'b1) begin errors++; $display("FAIL jump_restart: got pc %h run %b expected 000/1", prog_ctr, running); end
    endtask

    task automatic test_call_ret();
        wr_lut(3'd1, 12'h040);
        cyc();
        cyc();
        call_en = 1'b1; lut_sel = 3'd1;
        cyc();
        checks++; if (prog_ctr !== 12'h040) begin errors++; $display("FAIL call: got %h expected 040", prog_ctr); end
        ret_en = 1'b1;
        cyc();
        checks++; if (prog_ctr !== 12'h004) begin errors++; $display("FAIL ret: got %h expected 004", prog_ctr); end
        for (int i = 0; i < 4; i++) begin
            call_en = 1'b1; lut_sel = 3'd1;
            cyc();
            checks++; if (prog_ctr !== 12'h040 || fault !== 1'b0) begin errors++; $display("FAIL nest_call: got pc %h fault %b expected 040/0", prog_ctr, fault); end
        end
        call_en = 1'b1; lut_sel = 3'd1;
        cyc();
        checks++; if (prog_ctr !== 12'h040 || fault !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL overflow: got pc %h fault %b run %b expected 040/1/0", prog_ctr, fault, running); end
        req = 1'b1;
        cyc();
        checks++; if (prog_ctr !== 12'h040 || fault !== 1'b1) begin errors++; $display("FAIL fault_req: got pc %h fault %b expected 040/1", prog_ctr, fault); end
        reset = 1'b1;
        cyc();
        checks++; if (prog_ctr !== 12'h000 || fault !== 1'b0) begin errors++; $display("FAIL fault_reset: got pc %h fault %b expected 000/0", prog_ctr, fault); end
    endtask

    task automatic test_priority_stall();
        req = 1'b1;
        cyc();
        wr_lut(3'd1, 12'h020);
        wr_lut(3'd2, 12'h030);
        call_en = 1'b1; lut_sel = 3'd1;
        cyc();
        ret_en = 1'b1; call_en = 1'b1; abs_en = 1'b1; lut_sel = 3'd2;
        cyc();
        checks++; if (prog_ctr !== 12'h003) begin errors++; $display("FAIL priority: got %h expected 003", prog_ctr); end
        stall = 1'b1; call_en = 1'b1; lut_sel = 3'd1;
        cyc();
        checks++; if (prog_ctr !== 12'h003 || running !== 1'b1) begin errors++; $display("FAIL stall_call: got pc %h run %b expected 003/1", prog_ctr, running); end
        stall = 1'b1;
        cyc();
        checks++; if (prog_ctr !== 12'h003) begin errors++; $display("FAIL stall_hold: got %h expected 003", prog_ctr); end
        ret_en = 1'b1;
        cyc();
        checks++; if (prog_ctr !== 12'h003 || fault !== 1'b1) begin errors++; $display("FAIL underflow: got pc %h fault %b expected 003/1", prog_ctr, fault); end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_reset_mid_run();
        req = 1'b1;
        cyc();
        wr_lut(3'd5, 12'h030);
        wr_lut(3'd6, 12'h02E);
        call_en = 1'b1; lut_sel = 3'd6;
        cyc();
        call_en = 1'b1; lut_sel = 3'd6;
        cyc();
        cyc();
        cyc();
        checks++; if (prog_ctr !== 12'h030) begin errors++; $display("FAIL mid_pre: got %h expected 030", prog_ctr); end
        reset = 1'b1;
        cyc();
        checks++; if (prog_ctr !== 12'h000 || {running, done, fault} !== 3'b000) begin errors++; $display("FAIL mid_reset: got pc %h flags %b expected 000/000", prog_ctr, {running, done, fault}); end
        cyc();
        checks++; if (prog_ctr !== 12'h000 || running !== 1'b0) begin errors++; $display("FAIL mid_idle: got pc %h run %b expected 000/0", prog_ctr, running); end
        req = 1'b1;
        cyc();
        abs_en = 1'b1; lut_sel = 3'd5;
        cyc();
        checks++; if (prog_ctr !== 12'h000) begin errors++; $display("FAIL table_cleared: got %h expected 000", prog_ctr); end
        ret_en = 1'b1;
        cyc();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL stack_cleared: got fault %b expected 1", fault); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #2;
        test_reset();
        test_run_to_done();
        test_abs_jump();
        test_rel_jump();
        test_end_via_jump();
        test_call_ret();
        test_priority_stall();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
